// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a shared MIPS load/store/R/I
// datapath through FETCH, DECODE, EXEC, MEM and WB, with a data-memory
// ready handshake.
// Optional feature: define MC_BEQ_EN to add the beq BRANCH state and pc_src.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       zero_flag,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic [3:0] ALU_OP,
    output logic       instr_done,
`ifdef MC_BEQ_EN
    output logic       illegal_instr,
    output logic       pc_src
`else
    output logic       illegal_instr
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_BRANCH = 3'd6;

    localparam logic [2:0] CLS_ILL  = 3'd0;
    localparam logic [2:0] CLS_LW   = 3'd1;
    localparam logic [2:0] CLS_SW   = 3'd2;
    localparam logic [2:0] CLS_R    = 3'd3;
    localparam logic [2:0] CLS_I    = 3'd4;
    localparam logic [2:0] CLS_BEQ  = 3'd5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    logic [2:0] state_reg, state_next;
    logic [2:0] cls_reg;
    logic [3:0] alu_op_reg;
    logic       alu_src_reg;
    logic       reg_dst_reg;

    logic [2:0] dec_cls;
    logic [3:0] dec_alu;
    logic       dec_src;
    logic       dec_rdst;

`ifndef MC_BEQ_EN
    // The branch compare result has no consumer without the branch class.
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
`endif

    // Instruction decode of the freshly loaded opcode/funct; only consumed in DECODE.
    always_comb begin
        dec_cls  = CLS_ILL;
        dec_alu  = ALU_ADD;
        dec_src  = 1'b0;
        dec_rdst = 1'b0;
        case (opcode)
            6'b100011: begin dec_cls = CLS_LW; dec_src = 1'b1; end
            6'b101011: begin dec_cls = CLS_SW; dec_src = 1'b1; end
            6'b001000: begin dec_cls = CLS_I;  dec_src = 1'b1; dec_alu = ALU_ADD; end
            6'b001100: begin dec_cls = CLS_I;  dec_src = 1'b1; dec_alu = ALU_AND; end
            6'b001101: begin dec_cls = CLS_I;  dec_src = 1'b1; dec_alu = ALU_OR;  end
            6'b000000: begin
                dec_rdst = 1'b1;
                case (funct)
                    6'b100000: begin dec_cls = CLS_R; dec_alu = ALU_ADD; end
                    6'b100010: begin dec_cls = CLS_R; dec_alu = ALU_SUB; end
                    6'b100100: begin dec_cls = CLS_R; dec_alu = ALU_AND; end
                    6'b100101: begin dec_cls = CLS_R; dec_alu = ALU_OR;  end
                    6'b101010: begin dec_cls = CLS_R; dec_alu = ALU_SLT; end
                    default:   dec_cls = CLS_ILL;
                endcase
            end
`ifdef MC_BEQ_EN
            6'b000100: begin dec_cls = CLS_BEQ; dec_alu = ALU_SUB; end
`endif
            default: dec_cls = CLS_ILL;
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (dec_cls)
                    CLS_ILL: state_next = S_FETCH;
                    CLS_BEQ: state_next = S_BRANCH;
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC:   state_next = (cls_reg == CLS_LW || cls_reg == CLS_SW) ? S_MEM : S_WB;
            S_MEM: begin
                if (!mem_ready)
                    state_next = S_MEM;
                else if (cls_reg == CLS_LW)
                    state_next = S_WB;
                else
                    state_next = S_FETCH;
            end
            S_WB:     state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register plus the per-instruction class and ALU controls latched in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cls_reg     <= CLS_ILL;
            alu_op_reg  <= 4'b0000;
            alu_src_reg <= 1'b0;
            reg_dst_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                cls_reg <= dec_cls;
                // Illegal instructions leave the ALU controls of the previous one in place.
                if (dec_cls != CLS_ILL) begin
                    alu_op_reg  <= dec_alu;
                    alu_src_reg <= dec_src;
                    reg_dst_reg <= dec_rdst;
                end
            end
        end
    end

    // Moore control outputs from state and latched class. The ALU controls are
    // held from EXEC until the next DECODE so the ALU result stays stable.
    always_comb begin
        PCWrite    = (state_reg == S_FETCH);
        IRWrite    = (state_reg == S_FETCH);
        RegWrite   = (state_reg == S_WB);
        MemRead    = (state_reg == S_MEM) && (cls_reg == CLS_LW);
        MemWrite   = (state_reg == S_MEM) && (cls_reg == CLS_SW);
        MemtoReg   = (state_reg == S_WB)  && (cls_reg == CLS_LW);
        ALUSrc     = alu_src_reg;
        RegDst     = reg_dst_reg;
        ALU_OP     = alu_op_reg;
        instr_done = (state_reg == S_WB) || (state_reg == S_BRANCH) ||
                     ((state_reg == S_MEM) && (cls_reg == CLS_SW) && mem_ready);
        // The illegal flag must appear in DECODE itself, so it is the one output
        // qualified directly by the decoder rather than by a latched class.
        illegal_instr = (state_reg == S_DECODE) && (dec_cls == CLS_ILL);
    end

`ifdef MC_BEQ_EN
    // Branch-taken select, valid only while in BRANCH.
    always_comb begin
        pc_src = (state_reg == S_BRANCH) && zero_flag;
    end
`endif

endmodule
